// File: rtl/arm_word_reader_if.sv
// Stream port carrying translated ARM words from the reader to its consumer.
// A word moves on any cycle where out_valid and out_ready are both high.
interface arm_word_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/arm_word_reader.sv
// Drains ARM words from the output RAM behind the writer's pointer into a
// 2-entry FIFO feeding a valid/ready consumer, then pulses done.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start; base_adr is loaded into rd_ptr on start
// ST_READ   | issuing RAM reads while [rd_ptr, wr_ptr) is non-empty and
//           | there is room; leaves once the writer is done and all words
//           | have been delivered
// ST_FINISH | single cycle with done high, then back to idle
module arm_word_reader #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_adr,
   input  logic [ADDRESS_WIDTH-1:0] wr_ptr,
   input  logic                     wr_done,
   output logic                     ram_re,
   output logic [ADDRESS_WIDTH-1:0] ram_adr,
   input  logic [DATA_WIDTH-1:0]    ram_data,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] words_read,
   arm_word_reader_if.master        out_if
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_FINISH} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] ADR_ONE = ADDRESS_WIDTH'(1);

   state_t                     state;
   logic [ADDRESS_WIDTH-1:0]   rd_ptr;
   logic                       inflight;
   logic [DATA_WIDTH-1:0]      fifo_mem [2];
   logic                       fifo_wr_idx;
   logic                       fifo_rd_idx;
   logic [1:0]                 fifo_count;
   logic                       pop;
   logic                       push;
   logic                       issue;
   logic                       drained;
   logic [2:0]                 fill;

   // Words already owed to the FIFO (stored plus in flight) must stay at or
   // below two after this cycle's pop, so a stalled consumer never loses data.
   assign pop     = out_if.out_valid & out_if.out_ready;
   assign push    = inflight;
   assign fill    = {1'b0, fifo_count} + {2'b00, inflight};
   assign issue   = (state == ST_READ) && (rd_ptr != wr_ptr) &&
                    (fill < (3'd2 + {2'b00, pop}));
   assign drained = wr_done && (rd_ptr == wr_ptr) && !inflight &&
                    (fifo_count == 2'd0);

   assign ram_re           = issue;
   assign ram_adr          = rd_ptr;
   assign out_if.out_valid = (fifo_count != 2'd0);
   assign out_if.out_data  = fifo_mem[fifo_rd_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         inflight   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         words_read <= '0;
      end else begin
         inflight <= issue;
         done     <= 1'b0;
         if (issue) rd_ptr <= rd_ptr + ADR_ONE;
         if (pop) words_read <= words_read + ADR_ONE;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rd_ptr     <= base_adr;
                  words_read <= '0;
                  busy       <= 1'b1;
                  state      <= ST_READ;
               end
            end
            ST_READ: begin
               if (drained) begin
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
         fifo_wr_idx <= 1'b0;
         fifo_rd_idx <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[fifo_wr_idx] <= ram_data;
            fifo_wr_idx           <= ~fifo_wr_idx;
         end
         if (pop) fifo_rd_idx <= ~fifo_rd_idx;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_arm_word_reader.sv
// Bench for arm_word_reader: directed scenarios plus randomized drains, all
// checked every cycle against a word-count model of the drain.
module tb_arm_word_reader;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start;
   logic [AW-1:0] base_adr;
   logic [AW-1:0] wr_ptr;
   logic          wr_done;
   logic          ram_re;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_data = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] words_read;

   arm_word_reader_if #(.DATA_WIDTH(DW)) out_if ();

   arm_word_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start),
      .base_adr   (base_adr),
      .wr_ptr     (wr_ptr),
      .wr_done    (wr_done),
      .ram_re     (ram_re),
      .ram_adr    (ram_adr),
      .ram_data   (ram_data),
      .busy       (busy),
      .done       (done),
      .words_read (words_read),
      .out_if     (out_if)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [1024];
   always @(posedge clk) if (ram_re) ram_data <= mem[ram_adr];

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a drain is just "issued" and "delivered" word counts from m_base.
   bit            m_busy = 0, m_fin = 0, prev_issue = 0;
   logic [AW-1:0] m_base = '0;
   int            issued = 0, delivered = 0, done_cnt = 0;
   int            outst, fifo_n;
   bit            e_valid, e_pop, e_re, e_fin;
   logic [AW-1:0] rdp;
   logic [AW-1:0] adr_q [$];
   logic [DW-1:0] got_q [$];
   int            got_cyc [$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 0; m_fin = 0; issued = 0; delivered = 0; prev_issue = 0;
      end else begin
         outst   = issued - delivered;
         fifo_n  = outst - (prev_issue ? 1 : 0);
         e_valid = m_busy && (fifo_n != 0);
         e_pop   = e_valid && out_if.out_ready;
         rdp     = m_base + AW'(issued);
         e_re    = m_busy && !m_fin && (rdp != wr_ptr) && ((outst - (e_pop ? 1 : 0)) < 2);
         e_fin   = m_busy && !m_fin && wr_done && (rdp == wr_ptr) && (outst == 0);
         chk("busy", busy, m_busy);
         chk("out_valid", out_if.out_valid, e_valid);
         chk("ram_re", ram_re, e_re);
         chk("done", done, m_fin);
         if (ram_re) begin
            chk("ram_adr", ram_adr, rdp);
            adr_q.push_back(ram_adr);
         end
         if (m_busy) chk("words_read", words_read, AW'(delivered));
         if (e_pop) begin
            chk("out_data", out_if.out_data, mem[m_base + AW'(delivered)]);
            got_q.push_back(out_if.out_data);
            got_cyc.push_back(cyc_cnt);
         end
         if (done) done_cnt++;
         issued     += e_re ? 1 : 0;
         delivered  += e_pop ? 1 : 0;
         prev_issue = e_re;
         if (m_fin) begin
            m_busy = 0; m_fin = 0;
         end else if (e_fin) begin
            m_fin = 1;
         end else if (!m_busy && start) begin
            m_busy = 1; m_base = base_adr; issued = 0; delivered = 0; prev_issue = 0;
         end
      end
   end

   int done_base = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b);
      start = 1'b1;
      base_adr = b;
      cyc();
      start = 1'b0;
   endtask

   task automatic clear_rec();
      adr_q.delete();
      got_q.delete();
      got_cyc.delete();
      done_base = done_cnt;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic wait_done(input int budget, input string nm);
      int k;
      k = 0;
      while (!done && k < budget) begin
         cyc();
         k++;
      end
      chk({nm, "_done_seen"}, done, 1);
      if (!done) do_reset();
      else cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] basic_w [4];
      logic [AW-1:0] wrap_a [4];
      int            k, n_re, len;
      logic [AW-1:0] b, fin;

      basic_w[0] = 32'hE3A00001; basic_w[1] = 32'hE3A00002;
      basic_w[2] = 32'hE52D0004; basic_w[3] = 32'hE3A00003;
      wrap_a[0] = 10'd1022; wrap_a[1] = 10'd1023; wrap_a[2] = 10'd0; wrap_a[3] = 10'd1;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = basic_w[i];

      start = 1'b0; base_adr = '0; wr_ptr = '0; wr_done = 1'b0;
      out_if.out_ready = 1'b0;
      rst_n = 1'b0;
      cyc(); cyc();
      chk("rst_ram_re", ram_re, 0);
      chk("rst_out_valid", out_if.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_words_read", words_read, 0);
      chk("rst_out_data", out_if.out_data, 0);
      chk("rst_ram_adr", ram_adr, 0);
      rst_n = 1'b1;
      cyc();

      // Basic drain
      wr_ptr = 10'd4; wr_done = 1'b1; out_if.out_ready = 1'b1;
      clear_rec();
      do_start(10'd0);
      k = 0;
      while (!out_if.out_valid && k < 10) begin
         cyc();
         k++;
      end
      chk("basic_latency", k, 2);
      wait_done(20, "basic");
      chk("basic_words_read", words_read, 4);
      chk("basic_busy_end", busy, 0);
      chk("basic_done_pulses", done_cnt - done_base, 1);
      chk("basic_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("basic_word", got_q[i], basic_w[i]);
      chk("basic_back_to_back", got_cyc[3] - got_cyc[0], 3);

      // Backpressure
      out_if.out_ready = 1'b0;
      clear_rec();
      do_start(10'd0);
      n_re = 0;
      repeat (5) begin
         @(negedge clk);
         n_re += ram_re ? 1 : 0;
         if (out_if.out_valid) chk("bp_hold", out_if.out_data, 32'hE3A00001);
         cyc();
      end
      chk("bp_re_at_most_2", n_re <= 2, 1);
      out_if.out_ready = 1'b1;
      wait_done(20, "bp");
      chk("bp_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("bp_word", got_q[i], basic_w[i]);
      chk("bp_words_read", words_read, 4);

      // Tracking the writer
      wr_ptr = 10'd0; wr_done = 1'b0;
      clear_rec();
      do_start(10'd0);
      for (int s = 1; s <= 3; s++) begin
         repeat (3) cyc();
         wr_ptr = AW'(s);
      end
      cyc();
      chk("track_busy", busy, 1);
      wr_done = 1'b1;
      wait_done(20, "track");
      chk("track_count", got_q.size(), 3);
      chk("track_last", got_q[2], 32'hE52D0004);
      chk("track_words_read", words_read, 3);
      chk("track_done_pulses", done_cnt - done_base, 1);

      // Wrap-around
      mem[1022] = 32'hE1A00000; mem[1023] = 32'hE2811001;
      wr_ptr = 10'd2; wr_done = 1'b1;
      clear_rec();
      do_start(10'd1022);
      wait_done(30, "wrap");
      chk("wrap_reads", adr_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("wrap_adr", adr_q[i], wrap_a[i]);
      chk("wrap_words_read", words_read, 4);
      chk("wrap_first_word", got_q[0], 32'hE1A00000);

      // Empty region with an ignored second start
      wr_ptr = 10'd5; wr_done = 1'b1;
      clear_rec();
      do_start(10'd5);
      start = 1'b1; base_adr = 10'd0;
      cyc();
      start = 1'b0;
      chk("empty_done", done, 1);
      cyc();
      chk("empty_busy_end", busy, 0);
      repeat (3) cyc();
      chk("empty_restart_ignored", busy, 0);
      chk("empty_no_reads", adr_q.size(), 0);
      chk("empty_done_pulses", done_cnt - done_base, 1);

      // Reset mid-drain
      wr_ptr = 10'd4; wr_done = 1'b1; out_if.out_ready = 1'b0;
      clear_rec();
      do_start(10'd0);
      cyc(); cyc();
      chk("mid_pre_valid", out_if.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_ram_re", ram_re, 0);
      chk("mid_out_valid", out_if.out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_words_read", words_read, 0);
      chk("mid_out_data", out_if.out_data, 0);
      chk("mid_ram_adr", ram_adr, 0);
      cyc();
      rst_n = 1'b1;
      out_if.out_ready = 1'b1;
      repeat (4) cyc();
      chk("mid_no_late_data", out_if.out_valid, 0);
      chk("mid_idle", busy, 0);

      // Randomized drains
      for (int d = 0; d < 40; d++) begin
         len = $urandom_range(0, 24);
         b   = AW'($urandom);
         fin = b + AW'(len);
         for (int i = 0; i < len; i++) mem[b + AW'(i)] = $urandom;
         wr_ptr  = b + AW'($urandom_range(0, len));
         wr_done = (wr_ptr == fin) && ($urandom_range(0, 1) == 1);
         out_if.out_ready = ($urandom_range(0, 1) == 1);
         clear_rec();
         do_start(b);
         k = 0;
         while (!done && k < 400) begin
            out_if.out_ready = ($urandom_range(0, 3) != 0);
            if (wr_ptr != fin && $urandom_range(0, 2) == 0) wr_ptr = wr_ptr + AW'(1);
            else if (wr_ptr == fin && $urandom_range(0, 3) == 0) wr_done = 1'b1;
            start    = ($urandom_range(0, 15) == 0);
            base_adr = AW'($urandom);
            cyc();
            start = 1'b0;
            k++;
         end
         chk("rand_done_seen", done, 1);
         if (done) begin
            cyc();
            chk("rand_busy_end", busy, 0);
            chk("rand_count", got_q.size(), len);
            chk("rand_done_pulses", done_cnt - done_base, 1);
         end else begin
            do_reset();
         end
         wr_done = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
